// File: rtl/rv_pkg.sv
// Shared register-file definitions used by the writeback path.
package rv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO that buffers load results until the write port is free.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                pop_entry,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign pop_entry = mem[rd_ptr];

  // NOTE: storage is left unreset on purpose; the pointers and count define validity,
  // so clearing the array would only add reset fan-out for no functional gain.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter: ALU results win, load results drain from a FIFO,
// and a pending-write scoreboard lets decode stall on outstanding destinations.
module writeback_arbiter
  import rv_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = XLEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [ADDR_W-1:0]      alu_rd,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [ADDR_W-1:0]      ld_rd,
  input  logic [DATA_W-1:0]      ld_data,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_rd,
  input  logic [ADDR_W-1:0]      rs1,
  input  logic [ADDR_W-1:0]      rs2,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic                   wb_we,
  output logic [ADDR_W-1:0]      wb_addr,
  output logic [DATA_W-1:0]      wb_data,
  output logic [$clog2(DEPTH):0] ld_count
);

  localparam int NREGS = 2 ** ADDR_W;

  wb_entry_t         ld_entry;
  wb_entry_t         head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              sel_valid;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic [NREGS-1:0]  pending;
  logic [NREGS-1:0]  pending_nxt;

  assign ld_entry = '{rd: ld_rd, data: ld_data};
  assign ld_ready = !fifo_full;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (ld_valid && ld_ready),
    .push_entry (ld_entry),
    .pop        (pop),
    .pop_entry  (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (ld_count)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = REG_ZERO;
    sel_data  = '0;
    pop       = 1'b0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (!fifo_empty) begin
      pop       = 1'b1;
      sel_valid = 1'b1;
      sel_rd    = head.rd;
      sel_data  = head.data;
    end
  end

  // A selected x0 write still consumes its slot but never asserts the enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
    end else begin
      wb_we <= sel_valid && (sel_rd != REG_ZERO);
      if (sel_valid) begin
        wb_addr <= sel_rd;
        wb_data <= sel_data;
      end
    end
  end

  // Set is applied after clear so a newer issue to the same rd keeps it pending.
  always_comb begin
    pending_nxt = pending;
    if (wb_we) pending_nxt[wb_addr] = 1'b0;
    if (iss_valid && (iss_rd != REG_ZERO)) pending_nxt[iss_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending_nxt;
  end

  assign rs1_busy = pending[rs1];
  assign rs2_busy = pending[rs2];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: vector table plus a write scoreboard.
module tb_writeback_arbiter;
  import rv_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [2:0]  ld_count;

  writeback_arbiter #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .ld_count  (ld_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  r1;
    logic [4:0]  r2;
    int          ecount;
    logic        eb1;
    logic        eb2;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_t;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];
  ld_t model_fifo[$];
  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                              input logic iv, input logic [4:0] ird,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input int ecount, input logic eb1, input logic eb2);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat;
    v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2;
    v.ecount = ecount; v.eb1 = eb1; v.eb2 = eb2;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
    ld_valid  = v.lv; ld_rd  = v.lrd; ld_data  = v.ldat;
    iss_valid = v.iv; iss_rd = v.ird; rs1 = v.r1; rs2 = v.r2;
  endtask

  // Compare the write port against the scoreboard entry predicted for this edge.
  task automatic check_write(input string tag);
    wr_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, " wb_we"}, 32'(wb_we), 32'(e.we));
      check({tag, " wb_addr"}, 32'(wb_addr), 32'(e.addr));
      check({tag, " wb_data"}, wb_data, e.data);
    end else begin
      check({tag, " wb_we idle"}, 32'(wb_we), 32'd0);
    end
  endtask

  // One cycle: predict arbitration from the reference FIFO, clock, then compare.
  task automatic apply(input vec_t v, input string tag);
    ld_t h;
    wr_t e;
    bit  full_before;
    drive(v);
    full_before = (model_fifo.size() == DEPTH);
    if (v.av) begin
      e.we = (v.ard != 5'd0); e.addr = v.ard; e.data = v.adat;
      exp_q.push_back(e);
    end else if (model_fifo.size() > 0) begin
      h = model_fifo.pop_front();
      e.we = (h.rd != 5'd0); e.addr = h.rd; e.data = h.data;
      exp_q.push_back(e);
    end
    if (v.lv && !full_before) begin
      h.rd = v.lrd; h.data = v.ldat;
      model_fifo.push_back(h);
    end
    @(posedge clk);
    #1;
    check_write(tag);
    check({tag, " ld_count"}, 32'(ld_count), 32'(v.ecount));
    check({tag, " ld_ready"}, 32'(ld_ready), 32'(v.ecount != DEPTH));
    check({tag, " rs1_busy"}, 32'(rs1_busy), 32'(v.eb1));
    check({tag, " rs2_busy"}, 32'(rs2_busy), 32'(v.eb2));
  endtask

  // Hold reset with live traffic on every input; all of it must be discarded.
  task automatic reset_cycles(input int n, input string tag);
    reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd14; alu_data = 32'h77;
    ld_valid = 1'b1;  ld_rd = 5'd15;  ld_data = 32'h88;
    iss_valid = 1'b1; iss_rd = 5'd16; rs1 = 5'd13; rs2 = 5'd9;
    model_fifo.delete();
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s%0d wb_we", tag, i), 32'(wb_we), 32'd0);
      check($sformatf("%s%0d wb_addr", tag, i), 32'(wb_addr), 32'd0);
      check($sformatf("%s%0d wb_data", tag, i), wb_data, 32'd0);
      check($sformatf("%s%0d ld_count", tag, i), 32'(ld_count), 32'd0);
      check($sformatf("%s%0d ld_ready", tag, i), 32'(ld_ready), 32'd1);
      check($sformatf("%s%0d rs1_busy", tag, i), 32'(rs1_busy), 32'd0);
      check($sformatf("%s%0d rs2_busy", tag, i), 32'(rs2_busy), 32'd0);
    end
    reset = 1'b0;
  endtask

  initial begin
    vec_t idle;
    // av ard adat | lv lrd ldat | iv ird | r1 r2 | count b1 b2
    vecs[0]  = mk(0, 0, 0,            0, 0, 0,      1, 3,  3,  0, 0, 1, 0);
    vecs[1]  = mk(1, 3, 32'hABCD1234, 0, 0, 0,      0, 0,  3,  0, 0, 1, 0);
    vecs[2]  = mk(0, 0, 0,            0, 0, 0,      0, 0,  3,  0, 0, 0, 0);
    vecs[3]  = mk(1, 2, 32'h200,      1, 4, 32'h10, 0, 0,  2,  4, 1, 0, 0);
    vecs[4]  = mk(1, 2, 32'h201,      1, 5, 32'h11, 0, 0,  2,  4, 2, 0, 0);
    vecs[5]  = mk(1, 2, 32'h202,      1, 6, 32'h12, 0, 0,  2,  4, 3, 0, 0);
    vecs[6]  = mk(1, 2, 32'h203,      1, 7, 32'h13, 0, 0,  2,  4, 4, 0, 0);
    vecs[7]  = mk(1, 2, 32'h204,      1, 8, 32'h14, 0, 0,  2,  4, 4, 0, 0);
    vecs[8]  = mk(0, 0, 0,            0, 0, 0,      0, 0,  2,  4, 3, 0, 0);
    vecs[9]  = mk(0, 0, 0,            0, 0, 0,      0, 0,  2,  4, 2, 0, 0);
    vecs[10] = mk(0, 0, 0,            0, 0, 0,      0, 0,  2,  4, 1, 0, 0);
    vecs[11] = mk(0, 0, 0,            0, 0, 0,      0, 0,  2,  4, 0, 0, 0);
    vecs[12] = mk(0, 0, 0,            0, 0, 0,      0, 0,  2,  4, 0, 0, 0);
    vecs[13] = mk(1, 0, 32'hFFFFFFFF, 1, 0, 32'h55, 0, 0,  0,  0, 1, 0, 0);
    vecs[14] = mk(0, 0, 0,            0, 0, 0,      0, 0,  0,  0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0,            0, 0, 0,      1, 9,  0,  9, 0, 0, 1);
    vecs[16] = mk(1, 9, 32'h99,       0, 0, 0,      0, 0,  0,  9, 0, 0, 1);
    vecs[17] = mk(0, 0, 0,            0, 0, 0,      1, 9,  0,  9, 0, 0, 1);
    vecs[18] = mk(0, 0, 0,            0, 0, 0,      0, 0,  0,  9, 0, 0, 1);
    vecs[19] = mk(1, 2, 32'h300,      1, 10, 32'h20, 1, 13, 13, 9, 1, 1, 1);
    vecs[20] = mk(1, 2, 32'h301,      1, 11, 32'h21, 0, 0, 13, 9, 2, 1, 1);
    vecs[21] = mk(1, 2, 32'h302,      1, 12, 32'h22, 0, 0, 13, 9, 3, 1, 1);
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0);

    reset_cycles(2, "por");
    apply(idle, "idle_after_reset");

    for (int i = 0; i < 22; i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
    end

    // Mid-drain reset with three buffered loads and rs13/rs9 pending.
    reset_cycles(1, "midrst");
    for (int i = 0; i < 3; i++) begin
      idle.r1 = 5'd13; idle.r2 = 5'd9;
      apply(idle, $sformatf("post_rst%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
